// File: rtl/rnd_draw_if.sv
// Request/response and LFSR control bundle for rnd_draw.
interface rnd_draw_if #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 8
);
  logic             en_i;
  logic             seed_load_i;
  logic [WIDTH-1:0] seed_i;
  logic             req_i;
  logic [OUT_W-1:0] limit_i;
  logic             ready_o;
  logic             valid_o;
  logic [OUT_W-1:0] num_o;
  logic [WIDTH-1:0] state_o;

  modport master (
    output en_i, seed_load_i, seed_i, req_i, limit_i,
    input  ready_o, valid_o, num_o, state_o
  );

  modport slave (
    input  en_i, seed_load_i, seed_i, req_i, limit_i,
    output ready_o, valid_o, num_o, state_o
  );
endinterface

// File: rtl/rnd_draw.sv
// Fibonacci LFSR with a req/valid bounded-draw engine (rejection sampling, fallback on last try).
// Optional: RND_ZERO_GUARD_EN replaces an all-zero seed/state with SEED so the LFSR cannot lock up.
module rnd_draw #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
  parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
  parameter int               OUT_W     = 8,
  parameter int               MAX_TRIES = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  rnd_draw_if.slave  bus
);

  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  typedef enum logic {IDLE, DRAW} st_t;

  st_t              st, st_nxt;
  logic [WIDTH-1:0] lfsr, lfsr_nxt, step, load;
  logic [OUT_W-1:0] limit_q, limit_nxt, mask_q, mask_nxt;
  logic [OUT_W-1:0] num_q, num_nxt, v;
  logic [TRY_W-1:0] try_q, try_nxt;
  logic             valid_q, valid_nxt, hit, last;

  // Smallest 2^k-1 covering x: every bit at or below the top set bit of x.
  function automatic logic [OUT_W-1:0] fill_mask(input logic [OUT_W-1:0] x);
    fill_mask = '0;
    for (int i = 0; i < OUT_W; i++) fill_mask[i] = |(x >> i);
  endfunction

  always_comb begin
    step = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
    load = bus.seed_i;
`ifdef RND_ZERO_GUARD_EN
    if (lfsr == '0)       step = SEED;
    if (bus.seed_i == '0) load = SEED;
`endif
    lfsr_nxt = lfsr;
    if (bus.seed_load_i)                lfsr_nxt = load;
    else if (bus.en_i || st == DRAW)    lfsr_nxt = step;
  end

  always_comb begin
    st_nxt    = st;
    limit_nxt = limit_q;
    mask_nxt  = mask_q;
    try_nxt   = try_q;
    num_nxt   = num_q;
    valid_nxt = 1'b0;
    v         = lfsr[OUT_W-1:0] & mask_q;
    hit       = (limit_q == '0) || (v < limit_q);
    last      = (try_q == TRY_W'(MAX_TRIES - 1));
    case (st)
      IDLE: if (bus.req_i) begin
        limit_nxt = bus.limit_i;
        // limit 0 wraps to all ones, i.e. the full 2^OUT_W range
        mask_nxt  = fill_mask(bus.limit_i - OUT_W'(1));
        try_nxt   = '0;
        st_nxt    = DRAW;
      end
      DRAW: begin
        if (hit || last) begin
          // mask < 2*limit, so v - limit lands below limit on the fallback path
          num_nxt   = hit ? v : v - limit_q;
          valid_nxt = 1'b1;
          st_nxt    = IDLE;
        end else begin
          try_nxt = try_q + TRY_W'(1);
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st      <= IDLE;
      lfsr    <= SEED;
      limit_q <= '0;
      mask_q  <= '0;
      try_q   <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      st      <= st_nxt;
      lfsr    <= lfsr_nxt;
      limit_q <= limit_nxt;
      mask_q  <= mask_nxt;
      try_q   <= try_nxt;
      num_q   <= num_nxt;
      valid_q <= valid_nxt;
    end
  end

  assign bus.ready_o = (st == IDLE);
  assign bus.valid_o = valid_q;
  assign bus.num_o   = num_q;
  assign bus.state_o = lfsr;

endmodule

// File: tb/tb_rnd_draw.sv
// Scoreboard bench for rnd_draw: default build (MAX_TRIES=8) plus a MAX_TRIES=1 instance.
module tb_rnd_draw;

  typedef struct {
    logic [7:0] num;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc0 = 0;
  int   acc1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  rnd_draw_if #(.WIDTH(16), .OUT_W(8)) if0 ();
  rnd_draw_if #(.WIDTH(16), .OUT_W(8)) if1 ();

  rnd_draw u_dut (.clk_i(clk), .rst_ni(rst_n), .bus(if0));
  rnd_draw #(.MAX_TRIES(1)) u_dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  // Reference draw: advances s by one step per try, returns value and latency.
  function automatic void mdl_draw(input int tries, input logic [7:0] lim,
                                   inout logic [15:0] s, output logic [7:0] num, output int lat);
    logic [7:0] m, v;
    m = lim - 8'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    num = 8'h00;
    lat = 0;
    for (int t = 0; t < tries; t++) begin
      v = s[7:0] & m;
      s = step(s);
      if (lim == 8'd0 || v < lim) begin
        num = v;
        lat = t + 2;
        return;
      end
      if (t == tries - 1) begin
        num = v - lim;
        lat = t + 2;
      end
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (if0.valid_o) begin
        if (q0.size() == 0) chk("unexp_valid0", 1, 0);
        else begin
          e = q0.pop_front();
          chk("num0", if0.num_o, e.num);
          chk("lat0", cyc - acc0, e.lat);
        end
      end
      if (if1.valid_o) begin
        if (q1.size() == 0) chk("unexp_valid1", 1, 0);
        else begin
          e = q1.pop_front();
          chk("num1", if1.num_o, e.num);
          chk("lat1", cyc - acc1, e.lat);
        end
      end
      if (if0.req_i && if0.ready_o) acc0 = cyc;
      if (if1.req_i && if1.ready_o) acc1 = cyc;
    end
  end

  task automatic idle_inputs();
    if0.en_i = 0; if0.seed_load_i = 0; if0.seed_i = '0; if0.req_i = 0; if0.limit_i = '0;
    if1.en_i = 0; if1.seed_load_i = 0; if1.seed_i = '0; if1.req_i = 0; if1.limit_i = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic draw(input bit sel, input logic [7:0] lim, input logic [7:0] enum_v, input int elat);
    exp_t e;
    bit   ok = 0;
    e.num = enum_v;
    e.lat = elat;
    if (sel) begin q1.push_back(e); if1.req_i = 1; if1.limit_i = lim; end
    else     begin q0.push_back(e); if0.req_i = 1; if0.limit_i = lim; end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = sel ? if1.ready_o : if0.ready_o;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if0.req_i = 0;
    if1.req_i = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      chk("valid_timeout", q0.size() + q1.size(), 0);
      q0.delete();
      q1.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] s;
    logic [7:0]  n8, lim;
    int          lat, steps;

    idle_inputs();
    rst_n = 0;
    #12;
    chk("rst_ready", if0.ready_o, 1);
    chk("rst_valid", if0.valid_o, 0);
    chk("rst_num", if0.num_o, 0);
    chk("rst_state", if0.state_o, 16'hACE1);
    chk("rst_ready1", if1.ready_o, 1);
    @(posedge clk); #1;
    rst_n = 1;

    // Free-run sequence and period
    if0.en_i = 1;
    @(negedge clk); chk("fr0", if0.state_o, 16'hACE1);
    @(negedge clk); chk("fr1", if0.state_o, 16'h59C3);
    @(negedge clk); chk("fr2", if0.state_o, 16'hB387);
    steps = 2;
    while (if0.state_o != 16'hACE1 && steps < 70000) begin
      @(negedge clk);
      steps++;
    end
    chk("period", steps, 65535);
    if0.en_i = 0;

    do_reset(); draw(0, 8'd0,   8'hE1, 2); wait_idle();
    do_reset(); draw(0, 8'd200, 8'hC3, 3); wait_idle();
    do_reset(); draw(0, 8'd1,   8'h00, 2); wait_idle();
    do_reset(); draw(0, 8'd10,  8'h01, 2); wait_idle();
    do_reset(); draw(1, 8'd200, 8'd25, 2); wait_idle();

    // Back-to-back draws against the reference model
    do_reset();
    s = 16'hACE1;
    for (int i = 0; i < 14; i++) begin
      case (i)
        0: lim = 8'd0;
        1: lim = 8'd1;
        2: lim = 8'd255;
        3: lim = 8'd129;
        4: lim = 8'd2;
        default: lim = 8'($urandom_range(0, 255));
      endcase
      mdl_draw(8, lim, s, n8, lat);
      draw(0, lim, n8, lat);
    end
    wait_idle();
    chk("state_after_draws", if0.state_o, s);

    // Seed load and request in the same IDLE cycle
    @(posedge clk); #1;
    if0.seed_load_i = 1;
    if0.seed_i = 16'h1234;
    draw(0, 8'd0, 8'h34, 2);
    if0.seed_load_i = 0;
    wait_idle();
    chk("seed_req_state", if0.state_o, step(16'h1234));

    // Zero seed handling
    do_reset();
    if0.seed_load_i = 1;
    if0.seed_i = 16'h0000;
    @(posedge clk); #1;
    if0.seed_load_i = 0;
    @(negedge clk);
`ifdef RND_ZERO_GUARD_EN
    chk("guard_load", if0.state_o, 16'hACE1);
`else
    chk("guard_load", if0.state_o, 16'h0000);
`endif
    if0.en_i = 1;
    repeat (3) @(negedge clk);
`ifdef RND_ZERO_GUARD_EN
    chk("guard_run", if0.state_o, step(step(step(16'hACE1))));
`else
    chk("guard_run", if0.state_o, 16'h0000);
`endif
    if0.en_i = 0;

    // Reset mid-draw: no valid, outputs back to reset values at once
    do_reset();
    if0.req_i = 1;
    if0.limit_i = 8'd200;
    @(posedge clk); #1;
    if0.req_i = 0;
    chk("mid_busy", if0.ready_o, 0);
    #2;
    rst_n = 0;
    #1;
    chk("mid_ready", if0.ready_o, 1);
    chk("mid_valid", if0.valid_o, 0);
    chk("mid_num", if0.num_o, 0);
    chk("mid_state", if0.state_o, 16'hACE1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (6) @(negedge clk);
    chk("mid_no_valid", if0.valid_o, 0);
    chk("queue_empty", q0.size() + q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
